input_peripherals: RTL and testbench
====================================

# input_peripherals

PS/2 keyboard receiver, (S)NES gamepad reader and one millisecond OS timer, grouped into one block. It sits between the memory-mapped I/O decoder and the board pins. The decoder reads `nesState` and `rx_data`, and pulses `setValue`/`trigger` on CPU writes. The block raises `rx_done_tick` and `interrupt` to the interrupt controller.

## Interface
Parameters:
- `NES_TICK`, default 150: clk cycles per pad half-bit (6 µs at 25 MHz).
- `NES_POLL`, default 416667: clk cycles between pad polls (about 60 Hz).
- `MS_DIV`, default 25000: clk cycles per timer millisecond.

Ports:
- `clk` in 1: the single clock; all logic samples on its rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `ps2c` in 1: PS/2 clock pin, asynchronous.
- `ps2d` in 1: PS/2 data pin, asynchronous.
- `rx_en` in 1: enables the keyboard receiver.
- `rx_done_tick` out 1: one-cycle pulse when a scan code is complete.
- `rx_data` out 8: last received scan code.
- `nesc` out 1: pad clock, idles high.
- `nesl` out 1: pad latch, idles low.
- `nesd` in 1: pad serial data, active-low buttons.
- `nesState` out 16: button state, 1 = pressed; bit 0 is the first bit shifted out.
- `timerValue` in 32: timer preload, in ms.
- `setValue` in 1: loads `timerValue` into the reload register.
- `trigger` in 1: starts or restarts the countdown.
- `interrupt` out 1: one-cycle pulse at timer expiry.

## Operation
Keyboard:
- `ps2c` passes through a 2-flop synchronizer, then an 8-sample glitch filter. The filtered level changes only after 8 consecutive equal samples.
- A filtered falling edge clocks in `ps2d`, which is also synchronized.
- States:
  - IDLE: waits for an edge with `rx_en`=1 and data=0 (start bit).
  - DATA: 8 data bits, LSB first.
  - PARITY: the bit is captured and not checked.
  - STOP: on this edge, `rx_data` updates, `rx_done_tick` pulses, and the FSM returns to IDLE.
- An edge in IDLE with data=1 is ignored.
- `rx_en`=0 holds the FSM in IDLE; `rx_data` retains its value.

Pad reader:
- States:
  - WAIT: count `NES_POLL` cycles.
  - LATCH: `nesl`=1 for 2×`NES_TICK` cycles.
  - READ: 16 bit slots, each `NES_TICK` cycles with `nesc` low, then `NES_TICK` cycles with `nesc` high.
- Bit i is sampled from synchronized `nesd` on the last cycle of slot i's low phase.
- Bits shift into a 16-bit shift register.
- After bit 15, `nesState` = inverted shift register, loaded atomically. It never exposes a partial frame. The FSM then returns to WAIT.
- Disconnected pad (`nesd` pulled high) → `nesState`=0.

Timer:
- The reload register R is loaded by `setValue`.
- `trigger`:
  - Loads counter C from R.
  - Clears the ms prescaler.
  - Sets `running`.
- While running:
  - The prescaler counts 0..`MS_DIV`-1.
  - At wrap, C decrements if C>0.
  - When C=0, `interrupt` pulses for one cycle and `running` clears.
- R=0 at trigger → C=0 → `interrupt` the cycle after trigger.
- `trigger` while running restarts from R; no interrupt is issued for the aborted run.
- `setValue` while running changes R only; the active count is unaffected.
- `setValue` and `trigger` in the same cycle: the count starts from the new `timerValue`.

Arithmetic:
- Counters are unsigned.
- C is 32-bit and never underflows.

## Timing
- Reset values (outputs and internal state):
  - `rx_done_tick`=0, `rx_data`=0, `nesState`=0.
  - `nesc`=1, `nesl`=0.
  - `interrupt`=0, R=0, C=0, not running.
  - All FSMs in IDLE/WAIT; the pad poll counter restarts from 0.
- Reset mid-frame or mid-count aborts immediately; there is no pending pulse after reset release.
- Keyboard latency: `rx_done_tick` asserts 2 sync cycles + 8 filter cycles + 1 cycle after the stop-bit falling edge of `ps2c`.
- Pad frame length: 2×`NES_TICK` latch + 32×`NES_TICK` bits.
- `nesState` updates one cycle after the final sample.
- Timer expiry: `interrupt` rises R×`MS_DIV`+1 cycles after the cycle in which `trigger` is high, for R≥1.
- All outputs are registered.

## Test plan
- PS/2 frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), `ps2c` period 80 clk → exactly one `rx_done_tick`; `rx_data`=0x1C.
- 3-cycle low glitch on `ps2c` while IDLE → no state change; a following valid 0xF0 frame is received correctly.
- Pad model driving 0xFFFE pattern (only bit 0 low), `NES_TICK`=4, `NES_POLL`=50 → `nesState`=0x0001 after the first frame; `nesc` shows 16 low pulses per frame and `nesl` shows one 8-cycle pulse.
- `MS_DIV`=10; `setValue` with 3, then `trigger` → `interrupt` exactly 31 cycles after trigger, one cycle wide, never again until the next trigger.
- Timer running with R=5; re-`trigger` at 30 cycles → the first run produces no interrupt; `interrupt` at 51 cycles after the second trigger. Separately, `setValue`+`trigger` with 0 → `interrupt` 1 cycle later.
- `reset` asserted mid PS/2 frame and mid countdown → `rx_done_tick`/`interrupt` stay 0; `nesc`=1, `nesl`=0, `nesState`=0; the next full frame after release decodes correctly.

Source files
------------

// File: rtl/input_peripherals.sv
// PS/2 keyboard receiver, NES/SNES pad reader and millisecond OS timer.
// All outputs are registered; reset is asynchronous and active-low.
module input_peripherals #(
    parameter int NES_TICK = 150,
    parameter int NES_POLL = 416667,
    parameter int MS_DIV   = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        rx_en,
    output logic        rx_done_tick,
    output logic [7:0]  rx_data,
    output logic        nesc,
    output logic        nesl,
    input  logic        nesd,
    output logic [15:0] nesState,
    input  logic [31:0] timerValue,
    input  logic        setValue,
    input  logic        trigger,
    output logic        interrupt
);

    localparam logic [31:0] LP_POLL_M1 = 32'(NES_POLL - 1);
    localparam logic [31:0] LP_TICK    = 32'(NES_TICK);
    localparam logic [31:0] LP_TICK_M1 = 32'(NES_TICK - 1);
    localparam logic [31:0] LP_SLOT_M1 = 32'(2 * NES_TICK - 1);
    localparam logic [31:0] LP_MS_M1   = 32'(MS_DIV - 1);

    typedef enum logic [1:0] {
        KB_IDLE,
        KB_DATA,
        KB_PARITY,
        KB_STOP
    } kb_state_t;

    typedef enum logic [1:0] {
        NES_WAIT,
        NES_LATCH,
        NES_READ
    } nes_state_t;

    // ---------------- keyboard ----------------
    logic [1:0] r_c_sync;
    logic [1:0] r_d_sync;
    logic [7:0] r_filt;
    logic       r_fval;
    logic       w_fall;
    logic       w_d;
    kb_state_t  r_kb_state;
    kb_state_t  w_kb_next;
    logic [2:0] r_kb_cnt;
    logic [7:0] r_kb_sh;
    logic [7:0] r_rx_data;
    logic       r_rx_done;

    assign w_d    = r_d_sync[1];
    assign w_fall = r_fval && (r_filt == 8'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_filt   <= 8'hFF;
            r_fval   <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c};
            r_d_sync <= {r_d_sync[0], ps2d};
            r_filt   <= {r_filt[6:0], r_c_sync[1]};
            if (r_filt == 8'hFF) begin
                r_fval <= 1'b1;
            end else if (r_filt == 8'h00) begin
                r_fval <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kb_state <= KB_IDLE;
        end else begin
            r_kb_state <= w_kb_next;
        end
    end

    always_comb begin
        w_kb_next = r_kb_state;
        if (!rx_en) begin
            w_kb_next = KB_IDLE;
        end else if (w_fall) begin
            case (r_kb_state)
                KB_IDLE:   if (!w_d) w_kb_next = KB_DATA;
                KB_DATA:   if (r_kb_cnt == 3'd7) w_kb_next = KB_PARITY;
                KB_PARITY: w_kb_next = KB_STOP;
                KB_STOP:   w_kb_next = KB_IDLE;
                default:   w_kb_next = KB_IDLE;
            endcase
        end
    end

    // Parity is clocked past without being stored or checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kb_cnt  <= 3'd0;
            r_kb_sh   <= 8'h00;
            r_rx_data <= 8'h00;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (rx_en && w_fall) begin
                case (r_kb_state)
                    KB_IDLE: r_kb_cnt <= 3'd0;
                    KB_DATA: begin
                        r_kb_sh  <= {w_d, r_kb_sh[7:1]};
                        r_kb_cnt <= r_kb_cnt + 3'd1;
                    end
                    KB_STOP: begin
                        r_rx_data <= r_kb_sh;
                        r_rx_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_done_tick = r_rx_done;

    // ---------------- pad reader ----------------
    nes_state_t  r_nes_state;
    nes_state_t  w_nes_next;
    logic [31:0] r_nes_cnt;
    logic [31:0] w_cnt_next;
    logic [3:0]  r_nes_bit;
    logic [3:0]  w_bit_next;
    logic [15:0] r_nes_sh;
    logic [15:0] r_nes_state_q;
    logic        r_nes_done;
    logic [1:0]  r_nesd_sync;
    logic        r_nesc;
    logic        r_nesl;
    logic        w_sample;

    always_comb begin
        w_nes_next = r_nes_state;
        w_cnt_next = r_nes_cnt + 32'd1;
        w_bit_next = r_nes_bit;
        case (r_nes_state)
            NES_WAIT: begin
                if (r_nes_cnt == LP_POLL_M1) begin
                    w_nes_next = NES_LATCH;
                    w_cnt_next = 32'd0;
                end
            end
            NES_LATCH: begin
                if (r_nes_cnt == LP_SLOT_M1) begin
                    w_nes_next = NES_READ;
                    w_cnt_next = 32'd0;
                    w_bit_next = 4'd0;
                end
            end
            NES_READ: begin
                if (r_nes_cnt == LP_SLOT_M1) begin
                    w_cnt_next = 32'd0;
                    if (r_nes_bit == 4'd15) begin
                        w_nes_next = NES_WAIT;
                    end else begin
                        w_bit_next = r_nes_bit + 4'd1;
                    end
                end
            end
            default: begin
                w_nes_next = NES_WAIT;
                w_cnt_next = 32'd0;
            end
        endcase
    end

    assign w_sample = (r_nes_state == NES_READ) && (r_nes_cnt == LP_TICK_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nes_state <= NES_WAIT;
            r_nes_cnt   <= 32'd0;
            r_nes_bit   <= 4'd0;
        end else begin
            r_nes_state <= w_nes_next;
            r_nes_cnt   <= w_cnt_next;
            r_nes_bit   <= w_bit_next;
        end
    end

    // Pins are driven from the next state so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nesd_sync   <= 2'b11;
            r_nes_sh      <= 16'h0000;
            r_nes_done    <= 1'b0;
            r_nes_state_q <= 16'h0000;
            r_nesc        <= 1'b1;
            r_nesl        <= 1'b0;
        end else begin
            r_nesd_sync <= {r_nesd_sync[0], nesd};
            r_nesl      <= (w_nes_next == NES_LATCH);
            r_nesc      <= !((w_nes_next == NES_READ) && (w_cnt_next < LP_TICK));
            r_nes_done  <= w_sample && (r_nes_bit == 4'd15);
            if (w_sample) begin
                r_nes_sh <= {r_nesd_sync[1], r_nes_sh[15:1]};
            end
            if (r_nes_done) begin
                r_nes_state_q <= ~r_nes_sh;
            end
        end
    end

    assign nesc     = r_nesc;
    assign nesl     = r_nesl;
    assign nesState = r_nes_state_q;

    // ---------------- timer ----------------
    logic [31:0] r_reload;
    logic [31:0] r_count;
    logic [31:0] r_pre;
    logic        r_running;
    logic        r_irq;
    logic [31:0] w_load;

    assign w_load = setValue ? timerValue : r_reload;

    // The pulse fires on the prescaler wrap that takes C from 1 to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reload  <= 32'd0;
            r_count   <= 32'd0;
            r_pre     <= 32'd0;
            r_running <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (setValue) begin
                r_reload <= timerValue;
            end
            if (trigger) begin
                r_count <= w_load;
                r_pre   <= 32'd0;
                if (w_load == 32'd0) begin
                    r_running <= 1'b0;
                    r_irq     <= 1'b1;
                end else begin
                    r_running <= 1'b1;
                end
            end else if (r_running) begin
                if (r_pre == LP_MS_M1) begin
                    r_pre <= 32'd0;
                    if (r_count != 32'd0) begin
                        r_count <= r_count - 32'd1;
                    end
                    if (r_count <= 32'd1) begin
                        r_irq     <= 1'b1;
                        r_running <= 1'b0;
                    end
                end else begin
                    r_pre <= r_pre + 32'd1;
                end
            end
        end
    end

    assign interrupt = r_irq;

endmodule

// File: tb/tb_input_peripherals.sv
// Self-checking bench for input_peripherals: keyboard frames, pad frames,
// timer expiry/restart cases and mid-operation reset.
module tb_input_peripherals;

    localparam int TICK = 4;
    localparam int POLL = 50;
    localparam int MSD  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic        rx_en = 1'b1;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic        nesc;
    logic        nesl;
    logic        nesd;
    logic [15:0] nesState;
    logic [31:0] timerValue = 32'd0;
    logic        setValue = 1'b0;
    logic        trigger = 1'b0;
    logic        interrupt;

    int n_vec = 0;
    int n_err = 0;

    input_peripherals #(
        .NES_TICK(TICK),
        .NES_POLL(POLL),
        .MS_DIV(MSD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2c(ps2c),
        .ps2d(ps2d),
        .rx_en(rx_en),
        .rx_done_tick(rx_done_tick),
        .rx_data(rx_data),
        .nesc(nesc),
        .nesl(nesl),
        .nesd(nesd),
        .nesState(nesState),
        .timerValue(timerValue),
        .setValue(setValue),
        .trigger(trigger),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    // Pad model: latch presents bit 0, each nesc rising edge advances.
    logic [15:0] pad_pat = 16'hFFFE;
    logic [4:0]  pad_idx = 5'd0;
    logic        pad_prev_c = 1'b1;

    always @(negedge clk) begin
        if (nesl) begin
            pad_idx <= 5'd0;
        end else if (nesc && !pad_prev_c && pad_idx < 5'd16) begin
            pad_idx <= pad_idx + 5'd1;
        end
        pad_prev_c <= nesc;
    end

    assign nesd = (pad_idx < 5'd16) ? pad_pat[pad_idx[3:0]] : 1'b1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_got[$];

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) rx_got.push_back(rx_data);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        cyc(20);
        ps2c = 1'b0;
        cyc(40);
        ps2c = 1'b1;
        cyc(20);
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic push);
        if (push) exp_q.push_back(d);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d);
        ps2_bit(1'b1);
    endtask

    task automatic ps2_check(input string nm);
        logic [7:0] e;
        logic [7:0] g;
        cyc(30);
        check({nm, "-ticks"}, 32'(rx_got.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_got.size() > 0) begin
            e = exp_q.pop_front();
            g = rx_got.pop_front();
            check({nm, "-byte"}, 32'(g), 32'(e));
        end
        exp_q.delete();
        rx_got.delete();
    endtask

    task automatic pad_frame(input string nm, input logic [15:0] pat,
                             input logic [15:0] exp);
        int   k;
        int   w;
        int   falls;
        logic lastc;
        pad_pat = pat;
        k = 0;
        @(negedge clk);
        while (nesl !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        while (nesl !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({nm, "-sync"}, 32'(k < 500), 32'd1);
        w = 0;
        lastc = 1'b1;
        while (nesl === 1'b1 && w < 100) begin
            w++;
            lastc = nesc;
            @(negedge clk);
        end
        check({nm, "-latch"}, 32'(w), 32'(2 * TICK));
        falls = 0;
        for (int j = 0; j < 32 * TICK; j++) begin
            if (lastc === 1'b1 && nesc === 1'b0) falls++;
            lastc = nesc;
            @(negedge clk);
        end
        check({nm, "-clks"}, 32'(falls), 32'd16);
        check({nm, "-state"}, 32'(nesState), 32'(exp));
    endtask

    task automatic timer_seq(input logic [31:0] val, input logic set,
                             input int act_n, input logic act_trig,
                             input logic [31:0] act_val, input int win,
                             output int first, output int cnt);
        timerValue = val;
        setValue = set;
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
        setValue = 1'b0;
        first = -1;
        cnt = 0;
        for (int n = 1; n <= win; n++) begin
            if (interrupt === 1'b1) begin
                cnt++;
                if (first < 0) first = n;
            end
            if (n == act_n) begin
                timerValue = act_val;
                if (act_trig) trigger = 1'b1;
                else setValue = 1'b1;
            end
            cyc(1);
            trigger = 1'b0;
            setValue = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       en;
        logic       glitch;
        logic [7:0] exp_rx;
    } ps2_vec_t;

    typedef struct {
        logic [15:0] pat;
        logic [15:0] exp;
    } pad_vec_t;

    ps2_vec_t pv[4];
    pad_vec_t nv[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int c;
        int ic;

        pv[0] = '{8'h1C, 1'b1, 1'b0, 8'h1C};
        pv[1] = '{8'hF0, 1'b1, 1'b1, 8'hF0};
        pv[2] = '{8'h55, 1'b0, 1'b0, 8'hF0};
        pv[3] = '{8'hA7, 1'b1, 1'b0, 8'hA7};
        nv[0] = '{16'hFFFE, 16'h0001};
        nv[1] = '{16'hFFFF, 16'h0000};
        nv[2] = '{16'h5A5A, 16'hA5A5};

        cyc(5);
        check("rst-tick", 32'(rx_done_tick), 32'd0);
        check("rst-rxdata", 32'(rx_data), 32'd0);
        check("rst-nesc", 32'(nesc), 32'd1);
        check("rst-nesl", 32'(nesl), 32'd0);
        check("rst-nesstate", 32'(nesState), 32'd0);
        check("rst-irq", 32'(interrupt), 32'd0);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 3; i++) begin
            pad_frame($sformatf("pad%0d", i), nv[i].pat, nv[i].exp);
        end
        cyc(1);

        for (int i = 0; i < 4; i++) begin
            if (pv[i].glitch) begin
                ps2d = 1'b0;
                cyc(5);
                ps2c = 1'b0;
                cyc(3);
                ps2c = 1'b1;
                cyc(10);
                ps2d = 1'b1;
                cyc(20);
            end
            rx_en = pv[i].en;
            ps2_frame(pv[i].data, pv[i].en);
            rx_en = 1'b1;
            ps2_check($sformatf("ps2v%0d", i));
            check($sformatf("ps2v%0d-rxdata", i), 32'(rx_data),
                  32'(pv[i].exp_rx));
        end

        setValue = 1'b1;
        timerValue = 32'd3;
        cyc(1);
        setValue = 1'b0;
        cyc(3);
        timer_seq(32'd99, 1'b0, 0, 1'b0, 32'd0, 80, f, c);
        check("tmr3-at", 32'(f), 32'd31);
        check("tmr3-count", 32'(c), 32'd1);
        timer_seq(32'd0, 1'b0, 5, 1'b0, 32'd7, 80, f, c);
        check("tmrset-at", 32'(f), 32'd31);
        check("tmrset-count", 32'(c), 32'd1);
        timer_seq(32'd0, 1'b0, 0, 1'b0, 32'd0, 100, f, c);
        check("tmr7-at", 32'(f), 32'd71);
        check("tmr7-count", 32'(c), 32'd1);
        timer_seq(32'd5, 1'b1, 30, 1'b1, 32'd0, 120, f, c);
        check("tmrretrig-at", 32'(f), 32'd81);
        check("tmrretrig-count", 32'(c), 32'd1);
        timer_seq(32'd0, 1'b1, 0, 1'b0, 32'd0, 20, f, c);
        check("tmr0-at", 32'(f), 32'd1);
        check("tmr0-count", 32'(c), 32'd1);

        timer_seq(32'd100, 1'b1, 0, 1'b0, 32'd0, 5, f, c);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2d = 1'b0;
        cyc(20);
        ps2c = 1'b0;
        cyc(15);
        reset = 1'b0;
        cyc(3);
        check("midrst-tick", 32'(rx_done_tick), 32'd0);
        check("midrst-rxdata", 32'(rx_data), 32'd0);
        check("midrst-nesc", 32'(nesc), 32'd1);
        check("midrst-nesl", 32'(nesl), 32'd0);
        check("midrst-nesstate", 32'(nesState), 32'd0);
        check("midrst-irq", 32'(interrupt), 32'd0);
        ps2c = 1'b1;
        ps2d = 1'b1;
        cyc(5);
        reset = 1'b1;
        ic = 0;
        for (int n = 0; n < 1200; n++) begin
            if (interrupt === 1'b1) ic++;
            cyc(1);
        end
        check("postrst-irq", 32'(ic), 32'd0);
        check("postrst-ticks", 32'(rx_got.size()), 32'd0);
        rx_got.delete();
        ps2_frame(8'h1C, 1'b1);
        ps2_check("postrst-frame");
        check("postrst-rxdata", 32'(rx_data), 32'h1C);
        pad_frame("postrst-pad", 16'h5A5A, 16'hA5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
